// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared single-port RAM and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8
) ();
    logic              if_req;
    logic [PC_W-1:0]   if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_rw, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and load/store (data priority, starvation guard).
// Optional macro MEM_ARB_PERF_EN adds saturating grant/conflict performance counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_W         = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0] perf_if_grants,
    output logic [15:0] perf_d_grants,
    output logic [15:0] perf_conflicts
`endif
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_if_win;
    logic              w_d_win;
    logic              w_starved;
    logic [CNT_W-1:0]  r_starve_cnt;

    logic              r_owner_d;
    logic              r_op_write;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decode; grants exist only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_if_win    = 1'b0;
        w_d_win     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.d_req && !(bus.if_req && w_starved)) begin
                    w_d_win = 1'b1;
                end else if (bus.if_req) begin
                    w_if_win = 1'b1;
                end
                if (bus.d_req || bus.if_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Starvation counter: consecutive data grants taken while fetch was waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_d_win) begin
            if (!bus.if_req) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

    // RAM pin registers, latched at grant; write strobe is confined to ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_owner_d   <= 1'b0;
            r_op_write  <= 1'b0;
        end else begin
            if (w_d_win) begin
                r_mem_rw    <= bus.d_rw;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                r_owner_d   <= 1'b1;
                r_op_write  <= bus.d_rw;
            end else if (w_if_win) begin
                r_mem_rw   <= 1'b0;
                r_mem_addr <= ADDR_W'(bus.if_addr);
                r_owner_d  <= 1'b0;
                r_op_write <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                r_mem_rw <= 1'b0;
            end
        end
    end

    // Read-data capture in WAIT; completion pulse lands in the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (r_state == S_WAIT) begin
                if (r_owner_d) begin
                    r_d_rvalid <= 1'b1;
                    if (!r_op_write) begin
                        r_d_rdata <= bus.mem_rdata;
                    end
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = w_if_win;
    assign bus.d_gnt     = w_d_win;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != S_IDLE);

`ifdef MEM_ARB_PERF_EN
    logic [15:0] r_perf_if;
    logic [15:0] r_perf_d;
    logic [15:0] r_perf_conf;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_if   <= '0;
            r_perf_d    <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_if_win && (r_perf_if != 16'hFFFF)) begin
                r_perf_if <= r_perf_if + 16'd1;
            end
            if (w_d_win && (r_perf_d != 16'hFFFF)) begin
                r_perf_d <= r_perf_d + 16'd1;
            end
            if ((r_state == S_IDLE) && bus.if_req && bus.d_req && (r_perf_conf != 16'hFFFF)) begin
                r_perf_conf <= r_perf_conf + 16'd1;
            end
        end
    end

    assign perf_if_grants = r_perf_if;
    assign perf_d_grants  = r_perf_d;
    assign perf_conflicts = r_perf_conf;
`endif
endmodule
